// File: rtl/pwm_led_chaser_pkg.sv
// Shared types and helpers for the PWM LED chaser: operating modes and the
// power-on brightness ramp.
package pwm_led_chaser_pkg;

   typedef enum logic [1:0] {
      MODE_ROTATE = 2'b00,
      MODE_HOLD   = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_t;

   // Floor of i*period/n gives an evenly spaced gradient starting dark at channel 0.
   function automatic int ramp_init(input int i, input int n, input int period);
      return (i * period) / n;
   endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Free-running PWM phase counter plus the gated step counter that paces the
// chaser; tick is high on the last count of each step interval while enabled.
module pwm_tick_gen #(
   parameter int PWM_PERIOD = 100,
   parameter int STEP_TICKS = 25_000_000,
   parameter int DW         = $clog2(PWM_PERIOD + 1),
   parameter int SW         = $clog2(STEP_TICKS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          load,
   output logic [DW-1:0] pcnt,
   output logic          tick
);

   logic [SW-1:0] scnt;

   assign tick = en && (scnt == SW'(STEP_TICKS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pcnt <= '0;
      else if (pcnt == DW'(PWM_PERIOD - 1))
         pcnt <= '0;
      else
         pcnt <= pcnt + DW'(1);
   end

   // load restarts the step interval; a coincident tick still wraps to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         scnt <= '0;
      else if (load || tick)
         scnt <= '0;
      else if (en)
         scnt <= scnt + SW'(1);
   end

endmodule

// File: rtl/pwm_led_chaser.sv
// Multi-channel PWM LED chaser: per-channel duty registers compared against a
// shared PWM counter, rotated (or bounced) one position per step tick.
module pwm_led_chaser
   import pwm_led_chaser_pkg::*;
#(
   parameter int N_CH       = 10,
   parameter int PWM_PERIOD = 100,
   parameter int STEP_TICKS = 25_000_000,
   parameter int MON_CH     = N_CH / 2,
   localparam int DW        = $clog2(PWM_PERIOD + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            dir,
   input  logic [1:0]      mode,
   input  logic            load,
   output logic [N_CH-1:0] led,
   output logic [DW-1:0]   duty_mon,
   output logic            step_pulse
);

   localparam int BW = $clog2(N_CH);

   logic [DW-1:0] duty     [N_CH];
   logic [DW-1:0] shift_lo [N_CH];
   logic [DW-1:0] shift_hi [N_CH];
   logic [DW-1:0] pcnt;
   logic [BW-1:0] bpos;
   logic          bdir;
   logic          tick;
   logic          step;
   mode_t         cur_mode;

   pwm_tick_gen #(
      .PWM_PERIOD(PWM_PERIOD),
      .STEP_TICKS(STEP_TICKS),
      .DW        (DW)
   ) u_tick (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .load(load),
      .pcnt(pcnt),
      .tick(tick)
   );

   assign cur_mode = mode_t'(mode);
   assign step     = tick && !load;
   assign duty_mon = duty[MON_CH];

   // shift_lo moves values toward lower indices, shift_hi toward higher ones.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         shift_lo[i] = duty[(i + 1) % N_CH];
         shift_hi[i] = duty[(i + N_CH - 1) % N_CH];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++)
            duty[i] <= DW'(ramp_init(i, N_CH, PWM_PERIOD));
         bpos       <= '0;
         bdir       <= 1'b0;
         step_pulse <= 1'b0;
      end else if (load) begin
         for (int i = 0; i < N_CH; i++)
            duty[i] <= DW'(ramp_init(i, N_CH, PWM_PERIOD));
         bpos       <= '0;
         bdir       <= dir;
         step_pulse <= 1'b0;
      end else begin
         step_pulse <= step;
         if (cur_mode != MODE_BOUNCE) begin
            // Outside bounce the bounce state tracks dir so entry starts that way.
            bdir <= dir;
            bpos <= '0;
            if (step && cur_mode == MODE_ROTATE) begin
               if (dir)
                  duty <= shift_lo;
               else
                  duty <= shift_hi;
            end
         end else if (step) begin
            if (bdir)
               duty <= shift_lo;
            else
               duty <= shift_hi;
            if (bpos == BW'(N_CH - 2)) begin
               bpos <= '0;
               bdir <= ~bdir;
            end else begin
               bpos <= bpos + BW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         led <= '0;
      else
         for (int i = 0; i < N_CH; i++)
            led[i] <= (pcnt < duty[i]);
   end

endmodule

// File: doc/pwm_led_chaser.md
# pwm_led_chaser

Parametrised multi-channel PWM LED chaser: N_CH LED outputs, each driven by a free-running PWM comparator against its own duty register. At a programmable step interval, the duty registers rotate one position to produce a moving brightness gradient. Adds three modes (rotate, hold, bounce), an enable, a synchronous reload of the ramp, a step strobe and a monitor tap. It sits between the board-level switches/keys and the LED banks.

## Interface
- N_CH, 10, number of LED channels (≥ 2)
- PWM_PERIOD, 100, PWM counter counts 0..PWM_PERIOD-1; duty range 0..PWM_PERIOD
- STEP_TICKS, 25_000_000, clk cycles between rotation steps (≥ 2)
- MON_CH, N_CH/2, channel whose duty appears on duty_mon
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  1 = step counter runs; 0 = step counter frozen, PWM keeps running
- dir  input  1  1 = rotate toward lower index (duty[i] <= duty[i+1]); 0 = toward higher index
- mode  input  2  00 rotate, 01 hold, 10 bounce, 11 treated as hold
- load  input  1  synchronous one-cycle reload of the initial ramp
- led  output  N_CH  registered PWM outputs, 1 = lit
- duty_mon  output  DW  duty[MON_CH], where DW = $clog2(PWM_PERIOD+1)
- step_pulse  output  1  one-cycle strobe per step tick

## Operation
- PWM counter pcnt: increments every cycle and wraps from PWM_PERIOD-1 to 0. It is unaffected by en, mode and load.
- led[i] <= (pcnt < duty[i]). Duty 0 is always dark; duty PWM_PERIOD is always lit. Strict compare is required.
- Initial ramp: duty[i] = (i*PWM_PERIOD)/N_CH, integer floor, computed at elaboration.
- Step counter scnt: when en=1, counts 0..STEP_TICKS-1. The step tick occurs on the cycle scnt==STEP_TICKS-1 with en=1; scnt then wraps to 0.
- On a step tick, step_pulse is registered high for one cycle. This happens in every mode.
- Rotate (00): on a step tick, circular shift of all N_CH duties per dir, with end wrap (duty[N_CH-1] <= duty[0] for dir=1).
- Hold (01/11): duties are frozen and scnt still counts.
- Bounce (10): circular shift using internal direction bdir.
  - bpos counts steps 0..N_CH-2.
  - When bpos==N_CH-2 on a step tick, the shift still happens, then bpos returns to 0 and bdir toggles.
  - On any cycle with mode≠10, bdir <= dir and bpos <= 0, so entering bounce starts in dir's direction.
  - dir is ignored while in bounce.
- load: on that clock edge, duty <= initial ramp, scnt <= 0, bpos <= 0, bdir <= dir. load has priority over a coincident step tick: no shift and no step_pulse. pcnt is untouched.
- Mode or dir changes take effect at the next step tick. Nothing in flight is lost.

## Timing
- Reset values: pcnt=0, scnt=0, bpos=0, bdir=0, duty = initial ramp, led=0, step_pulse=0, duty_mon=ramp[MON_CH].
- led has one cycle of latency from pcnt/duty. The duty change on a step tick is visible on led two edges later.
- step_pulse goes high in the cycle after the tick edge, aligned with the new duty values; duty_mon is combinational from duty.
- Reset asserted mid-operation: all state returns to reset values immediately; no partial shift is retained.
- Width rules:
  - pcnt is DW bits.
  - scnt is $clog2(STEP_TICKS) bits.
  - bpos is $clog2(N_CH) bits.
  - Compares are unsigned with no truncation.

## Structure
- Package pwm_led_chaser_pkg holds:
  - the mode enum (MODE_ROTATE, MODE_HOLD, MODE_BOUNCE, MODE_RSVD);
  - a function ramp_init(i, n, period) returning the initial duty.
- One sub-module, pwm_tick_gen, holds pcnt and scnt and emits the step tick. The duty array, rotation/bounce logic and comparators live in the top.

## Test plan
Bench parameters: N_CH=4, PWM_PERIOD=8, STEP_TICKS=5, MON_CH=2.
- Reset release: duty={0,2,4,6}, led=0. Over 8 cycles led[0] is never lit, led[3] is lit 6 of 8, duty_mon=4.
- Rotate, dir=1, en=1: first step_pulse 5 cycles after reset release, then duty={2,4,6,0}. dir=0 from reset gives {6,0,2,4}.
- en=0 for 20 cycles: no step_pulse and duties unchanged, while led keeps toggling at the PWM rate. Re-enable resumes the count where it froze.
- Hold mode: step_pulse every 5 cycles, duties constant {0,2,4,6}.
- Bounce, dir=1 at entry: steps give {2,4,6,0}, {4,6,0,2}, {6,0,2,4}, then the direction flips to {4,6,0,2}, {2,4,6,0}, {0,2,4,6}, then flips again.
- load on the same edge as a step tick after two rotations: duty={0,2,4,6}, no step_pulse, next tick 5 cycles later. rst pulse mid-PWM-cycle: led=0 and pcnt=0 immediately.
